// File: rtl/pll_drp_ctrl_if.sv
// Configuration request and DRP port bundle for pll_drp_ctrl.
// master = controller side, slave = requester / DRP primitive side.
interface pll_drp_ctrl_if;
  logic        cfg_req;
  logic [6:0]  cfg_mult;
  logic [6:0]  cfg_div;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] drp_do;
  logic        drdy;

  modport master (
    input  cfg_req, cfg_mult, cfg_div, drp_do, drdy,
    output cfg_busy, cfg_done, cfg_err, daddr, den, dwe, di
  );

  modport slave (
    output cfg_req, cfg_mult, cfg_div, drp_do, drdy,
    input  cfg_busy, cfg_done, cfg_err, daddr, den, dwe, di
  );
endinterface

// File: rtl/pll_drp_ctrl.sv
// PLL DRP reconfiguration: read-modify-write of CLKOUT0/CLKFBOUT divider registers.
// Define PLL_DRP_TIMEOUT_EN to bound the drdy / pll_locked waits by TIMEOUT_CYCLES.
//  state     | meaning
//  IDLE      | waiting for cfg_req
//  RST_PLL   | PLL held in reset, register index cleared
//  RD        | DRP read strobe
//  RD_WAIT   | waiting for read drdy
//  WR        | DRP write strobe
//  WR_WAIT   | waiting for write drdy
//  LOCK_WAIT | PLL released, waiting for lock
module pll_drp_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic           clk_in,
  input  logic           rst,
  pll_drp_ctrl_if.master bus,
  output logic           pll_rst,
  input  logic           pll_locked
);

  typedef enum logic [2:0] {
    IDLE, RST_PLL, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [6:0]  r_mult, r_div;
  logic [6:0]  r_daddr, w_daddr_nxt;
  logic [15:0] r_di;
  logic        r_done, r_err, r_lock_arm;
  logic        w_done_nxt, w_err_nxt, w_req_ok, w_timeout;
  logic [6:0]  w_d;
  logic        w_d_one;
  logic [5:0]  w_hi, w_lo;
  logic [15:0] w_keep, w_new;

  assign w_req_ok = (bus.cfg_mult >= 7'd2) && (bus.cfg_mult <= 7'd64) &&
                    (bus.cfg_div  >= 7'd1) && (bus.cfg_div  <= 7'd64);

  // D=1 is encoded as high=low=1 with no_count; the edge bit must stay clear
  always_comb begin
    w_d     = r_idx[1] ? r_mult : r_div;
    w_d_one = (w_d == 7'd1);
    w_hi    = w_d_one ? 6'd1 : w_d[6:1];
    w_lo    = w_d_one ? 6'd1 : 6'(w_d - {1'b0, w_d[6:1]});
    if (!r_idx[0]) begin
      w_keep = 16'hF000;
      w_new  = {4'h0, w_hi, w_lo};
    end else begin
      w_keep = 16'hFF3F;
      w_new  = {8'h00, w_d[0] & ~w_d_one, w_d_one, 6'h00};
    end
  end

  always_comb begin
    case (w_idx_nxt)
      2'd0:    w_daddr_nxt = 7'h08;
      2'd1:    w_daddr_nxt = 7'h09;
      2'd2:    w_daddr_nxt = 7'h14;
      default: w_daddr_nxt = 7'h15;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cfg_req) begin
          if (w_req_ok) w_state_nxt = RST_PLL;
          else          w_err_nxt   = 1'b1;
        end
      end
      RST_PLL: begin
        w_idx_nxt   = 2'd0;
        w_state_nxt = RD;
      end
      RD: w_state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (bus.drdy) begin
          w_state_nxt = WR;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      WR: w_state_nxt = WR_WAIT;
      WR_WAIT: begin
        if (bus.drdy) begin
          if (r_idx == 2'd3) begin
            w_state_nxt = LOCK_WAIT;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = RD;
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      LOCK_WAIT: begin
        if (r_lock_arm && pll_locked) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      r_mult     <= 7'd0;
      r_div      <= 7'd0;
      r_daddr    <= 7'd0;
      r_di       <= 16'h0000;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_lock_arm <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      // lock status is ignored in the first LOCK_WAIT cycle
      r_lock_arm <= (r_state == LOCK_WAIT) && (w_state_nxt == LOCK_WAIT);
      if (r_state == IDLE && w_state_nxt == RST_PLL) begin
        r_mult <= bus.cfg_mult;
        r_div  <= bus.cfg_div;
      end
      if (w_state_nxt == RD) r_daddr <= w_daddr_nxt;
      if (r_state == RD_WAIT && bus.drdy) r_di <= (bus.drp_do & w_keep) | w_new;
    end
  end

`ifdef PLL_DRP_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_wait_entry;

  assign w_wait_entry = (w_state_nxt != r_state) &&
                        ((w_state_nxt == RD_WAIT) || (w_state_nxt == WR_WAIT) ||
                         (w_state_nxt == LOCK_WAIT));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_wait_entry) begin
      r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (r_tmo_cnt != '0) begin
      r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
    end
  end

  assign w_timeout = (r_tmo_cnt == '0);
`else
  assign w_timeout = 1'b0;

  // TIMEOUT_CYCLES only sizes the wait counter, which is absent in this build
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_unused
  end
`endif

  assign bus.cfg_busy = (r_state != IDLE);
  assign bus.cfg_done = r_done;
  assign bus.cfg_err  = r_err;
  assign bus.den      = (r_state == RD) || (r_state == WR);
  assign bus.dwe      = (r_state == WR);
  assign bus.daddr    = r_daddr;
  assign bus.di       = r_di;
  assign pll_rst      = (r_state == RST_PLL) || (r_state == RD) || (r_state == RD_WAIT) ||
                        (r_state == WR) || (r_state == WR_WAIT);

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Directed bench for pll_drp_ctrl: DRP slave answering 3 cycles after den, simple PLL lock model,
// one task per scenario with hand-computed register values.
`timescale 1ns/1ps
module tb_pll_drp_ctrl;
  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        pll_rst;
  logic        pll_locked;
  logic        drp_en = 1'b1;
  logic [15:0] rd_val = 16'hFFFF;
  logic [2:0]  drdy_sh = 3'b000;
  logic [3:0]  lock_sh = 4'h0;
  logic        den_prev = 1'b0;
  int          tests = 0;
  int          failed = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          den_viol = 0;
  logic [6:0]  q_addr[$];
  logic        q_we[$];
  logic [15:0] q_di[$];
  logic [6:0]  exp_addr[4] = '{7'h08, 7'h09, 7'h14, 7'h15};

  pll_drp_ctrl_if bus();

  pll_drp_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .bus       (bus),
    .pll_rst   (pll_rst),
    .pll_locked(pll_locked)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    drdy_sh <= {drdy_sh[1:0], bus.den & drp_en};
    lock_sh <= pll_rst ? 4'h0 : {lock_sh[2:0], 1'b1};
  end
  assign bus.drdy   = drdy_sh[2];
  assign bus.drp_do = bus.drdy ? rd_val : 16'h0000;
  assign pll_locked = lock_sh[3];

  always @(negedge clk_in) begin
    if (bus.den === 1'b1) begin
      q_addr.push_back(bus.daddr);
      q_we.push_back(bus.dwe);
      q_di.push_back(bus.di);
      if (den_prev) den_viol++;
    end
    den_prev = (bus.den === 1'b1);
    if (bus.cfg_done === 1'b1) done_cnt++;
    if (bus.cfg_err === 1'b1) err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    tests++; if (bus.cfg_busy !== 1'b0) begin failed++; $display("FAIL reset busy: got %b want 0", bus.cfg_busy); end
    tests++; if (bus.cfg_done !== 1'b0) begin failed++; $display("FAIL reset done: got %b want 0", bus.cfg_done); end
    tests++; if (bus.cfg_err !== 1'b0) begin failed++; $display("FAIL reset err: got %b want 0", bus.cfg_err); end
    tests++; if (bus.den !== 1'b0 || bus.dwe !== 1'b0) begin failed++; $display("FAIL reset den/dwe: got %b/%b want 0/0", bus.den, bus.dwe); end
    tests++; if (bus.daddr !== 7'h00 || bus.di !== 16'h0000) begin failed++; $display("FAIL reset daddr/di: got %h/%h want 00/0000", bus.daddr, bus.di); end
    tests++; if (pll_rst !== 1'b0) begin failed++; $display("FAIL reset pll_rst: got %b want 0", pll_rst); end
    rst = 1'b0;
    repeat (6) @(negedge clk_in);
  endtask

  task automatic test_sequence(input string name, input logic [6:0] m, input logic [6:0] d,
                               input logic [15:0] rv, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] wexp[4];
    int b, dc, ec, dv;
    bit seen;
    wexp[0] = w0; wexp[1] = w1; wexp[2] = w2; wexp[3] = w3;
    rd_val = rv;
    @(negedge clk_in);
    b = q_addr.size(); dc = done_cnt; ec = err_cnt; dv = den_viol;
    bus.cfg_mult = m; bus.cfg_div = d; bus.cfg_req = 1'b1;
    @(negedge clk_in);
    bus.cfg_req = 1'b0;
    tests++; if (bus.cfg_busy !== 1'b1 || pll_rst !== 1'b1) begin failed++; $display("FAIL %s start busy/pll_rst: got %b/%b want 1/1", name, bus.cfg_busy, pll_rst); end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.cfg_done === 1'b1) seen = 1'b1;
    end
    tests++; if (!seen) begin failed++; $display("FAIL %s done: got none within 200 cycles want pulse", name); end
    tests++; if (bus.cfg_busy !== 1'b0) begin failed++; $display("FAIL %s busy at done: got %b want 0", name, bus.cfg_busy); end
    repeat (4) @(negedge clk_in);
    #1;
    tests++; if (q_addr.size() - b != 8) begin failed++; $display("FAIL %s den count: got %0d want 8", name, q_addr.size() - b); end
    for (int i = 0; i < 8; i++) begin
      if (b + i < q_addr.size()) begin
        tests++;
        if (q_addr[b+i] !== exp_addr[i/2] || q_we[b+i] !== (i % 2 == 1)) begin
          failed++; $display("FAIL %s access%0d addr/we: got %h/%b want %h/%b", name, i, q_addr[b+i], q_we[b+i], exp_addr[i/2], (i % 2 == 1));
        end
        if (i % 2 == 1) begin
          tests++;
          if (q_di[b+i] !== wexp[i/2]) begin failed++; $display("FAIL %s write %h data: got %h want %h", name, exp_addr[i/2], q_di[b+i], wexp[i/2]); end
        end
      end
    end
    tests++; if (done_cnt - dc != 1 || err_cnt - ec != 0) begin failed++; $display("FAIL %s pulses done/err: got %0d/%0d want 1/0", name, done_cnt - dc, err_cnt - ec); end
    tests++; if (den_viol != dv) begin failed++; $display("FAIL %s den back-to-back: got %0d want 0", name, den_viol - dv); end
  endtask

  task automatic test_illegal();
    logic [6:0] vm[3] = '{7'd1, 7'd10, 7'd65};
    logic [6:0] vd[3] = '{7'd10, 7'd65, 7'd0};
    int b;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      b = q_addr.size();
      bus.cfg_mult = vm[k]; bus.cfg_div = vd[k]; bus.cfg_req = 1'b1;
      @(negedge clk_in);
      bus.cfg_req = 1'b0;
      tests++; if (bus.cfg_err !== 1'b1 || bus.cfg_busy !== 1'b0) begin failed++; $display("FAIL illegal%0d err/busy: got %b/%b want 1/0", k, bus.cfg_err, bus.cfg_busy); end
      @(negedge clk_in);
      tests++; if (bus.cfg_err !== 1'b0) begin failed++; $display("FAIL illegal%0d err width: got %b want 0", k, bus.cfg_err); end
      repeat (4) @(negedge clk_in);
      #1;
      tests++; if (q_addr.size() != b || pll_rst !== 1'b0 || bus.cfg_busy !== 1'b0) begin
        failed++; $display("FAIL illegal%0d idle: got den=%0d pll_rst=%b busy=%b want 0/0/0", k, q_addr.size() - b, pll_rst, bus.cfg_busy);
      end
    end
  endtask

  task automatic test_ignore_req();
    int b, dc, ec;
    bit seen;
    rd_val = 16'hFFFF;
    @(negedge clk_in);
    b = q_addr.size(); dc = done_cnt; ec = err_cnt;
    bus.cfg_mult = 7'd39; bus.cfg_div = 7'd20; bus.cfg_req = 1'b1;
    @(negedge clk_in);
    bus.cfg_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.drdy === 1'b1) seen = 1'b1;
    end
    tests++; if (!seen) begin failed++; $display("FAIL ignore drdy: got none within 50 cycles want pulse"); end
    bus.cfg_mult = 7'd10; bus.cfg_div = 7'd6; bus.cfg_req = 1'b1;
    @(negedge clk_in);
    bus.cfg_req = 1'b0;
    repeat (7) @(negedge clk_in);
    bus.cfg_req = 1'b1;
    @(negedge clk_in);
    bus.cfg_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.cfg_done === 1'b1) seen = 1'b1;
    end
    tests++; if (!seen) begin failed++; $display("FAIL ignore done: got none within 200 cycles want pulse"); end
    repeat (8) @(negedge clk_in);
    #1;
    tests++; if (q_addr.size() - b != 8) begin failed++; $display("FAIL ignore den count: got %0d want 8", q_addr.size() - b); end
    tests++; if (done_cnt - dc != 1 || err_cnt - ec != 0) begin failed++; $display("FAIL ignore done/err: got %0d/%0d want 1/0", done_cnt - dc, err_cnt - ec); end
    if (q_addr.size() - b >= 8) begin
      tests++; if (q_di[b+5] !== 16'hF4D4 || q_di[b+7] !== 16'hFFBF) begin
        failed++; $display("FAIL ignore fb writes: got %h/%h want F4D4/FFBF", q_di[b+5], q_di[b+7]);
      end
    end
  endtask

  task automatic test_rst_mid();
    int b, ec;
    bit seen;
    rd_val = 16'hFFFF;
    @(negedge clk_in);
    ec = err_cnt;
    bus.cfg_mult = 7'd39; bus.cfg_div = 7'd20; bus.cfg_req = 1'b1;
    @(negedge clk_in);
    bus.cfg_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.den === 1'b1 && bus.dwe === 1'b1 && bus.daddr === 7'h14) seen = 1'b1;
    end
    tests++; if (!seen) begin failed++; $display("FAIL rst_mid write 0x14: got none within 100 cycles want pulse"); end
    @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    tests++; if (bus.cfg_busy !== 1'b0 || bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
      failed++; $display("FAIL rst_mid busy/done/err: got %b/%b/%b want 0/0/0", bus.cfg_busy, bus.cfg_done, bus.cfg_err);
    end
    tests++; if (bus.den !== 1'b0 || bus.dwe !== 1'b0 || bus.daddr !== 7'h00 || bus.di !== 16'h0000 || pll_rst !== 1'b0) begin
      failed++; $display("FAIL rst_mid drp/pll: got den=%b dwe=%b daddr=%h di=%h pll_rst=%b want all 0", bus.den, bus.dwe, bus.daddr, bus.di, pll_rst);
    end
    rst = 1'b0;
    b = q_addr.size();
    repeat (10) @(negedge clk_in);
    #1;
    tests++; if (q_addr.size() != b || pll_rst !== 1'b0 || bus.cfg_busy !== 1'b0 || err_cnt != ec) begin
      failed++; $display("FAIL rst_mid quiet: got den=%0d pll_rst=%b busy=%b err=%0d want 0/0/0/0", q_addr.size() - b, pll_rst, bus.cfg_busy, err_cnt - ec);
    end
  endtask

`ifdef PLL_DRP_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    drp_en = 1'b0;
    @(negedge clk_in);
    bus.cfg_mult = 7'd39; bus.cfg_div = 7'd20; bus.cfg_req = 1'b1;
    @(negedge clk_in);
    bus.cfg_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.den === 1'b1) seen = 1'b1;
    end
    tests++; if (!seen) begin failed++; $display("FAIL timeout read strobe: got none within 20 cycles want pulse"); end
    repeat (16) @(negedge clk_in);
    tests++; if (bus.cfg_err !== 1'b0 || bus.cfg_busy !== 1'b1) begin failed++; $display("FAIL timeout early err/busy: got %b/%b want 0/1", bus.cfg_err, bus.cfg_busy); end
    @(negedge clk_in);
    tests++; if (bus.cfg_err !== 1'b1 || bus.cfg_busy !== 1'b0 || pll_rst !== 1'b0) begin
      failed++; $display("FAIL timeout err/busy/pll_rst: got %b/%b/%b want 1/0/0", bus.cfg_err, bus.cfg_busy, pll_rst);
    end
    @(negedge clk_in);
    tests++; if (bus.cfg_err !== 1'b0) begin failed++; $display("FAIL timeout err width: got %b want 0", bus.cfg_err); end
    drp_en = 1'b1;
  endtask
`else
  task automatic test_timeout();
    int ec;
    drp_en = 1'b0;
    @(negedge clk_in);
    ec = err_cnt;
    bus.cfg_mult = 7'd39; bus.cfg_div = 7'd20; bus.cfg_req = 1'b1;
    @(negedge clk_in);
    bus.cfg_req = 1'b0;
    repeat (60) @(negedge clk_in);
    #1;
    tests++; if (bus.cfg_busy !== 1'b1 || err_cnt != ec || pll_rst !== 1'b1) begin
      failed++; $display("FAIL no_timeout wait busy/err/pll_rst: got %b/%0d/%b want 1/0/1", bus.cfg_busy, err_cnt - ec, pll_rst);
    end
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    drp_en = 1'b1;
    @(negedge clk_in);
    tests++; if (bus.cfg_busy !== 1'b0) begin failed++; $display("FAIL no_timeout recover busy: got %b want 0", bus.cfg_busy); end
  endtask
`endif

  initial begin
    bus.cfg_req  = 1'b0;
    bus.cfg_mult = 7'd0;
    bus.cfg_div  = 7'd0;
    test_reset();
    test_sequence("basic", 7'd39, 7'd20, 16'hFFFF, 16'hF28A, 16'hFF3F, 16'hF4D4, 16'hFFBF);
    test_sequence("div1", 7'd2, 7'd1, 16'h0000, 16'h0041, 16'h0040, 16'h0041, 16'h0000);
    test_sequence("edge64", 7'd64, 7'd3, 16'h0000, 16'h0042, 16'h0080, 16'h0820, 16'h0000);
    test_illegal();
    test_ignore_req();
    test_rst_mid();
    test_sequence("after_rst", 7'd39, 7'd20, 16'hFFFF, 16'hF28A, 16'hFF3F, 16'hF4D4, 16'hFFBF);
    test_timeout();
    repeat (4) @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pll_drp_ctrl.md
PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, maximum cycles to wait for drdy or pll_locked.
REQ-002 clk_in  input  1  DRP clock; all logic is on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cfg_req  input  1  single-cycle request to apply cfg_mult/cfg_div.
REQ-005 cfg_mult  input  7  new CLKFBOUT multiplier; legal range 2..64.
REQ-006 cfg_div  input  7  new CLKOUT0 divider; legal range 1..64.
REQ-007 cfg_busy  output  1  high while a reconfiguration is in progress.
REQ-008 cfg_done  output  1  one-cycle pulse on successful completion.
REQ-009 cfg_err  output  1  one-cycle pulse on rejected request or timeout.
REQ-010 daddr  output  7  DRP address; den output 1; dwe output 1; di output 16 (DRP write data).
REQ-011 drp_do  input  16  DRP read data; drdy input 1  DRP transaction acknowledge.
REQ-012 pll_rst  output  1  PLL reset; pll_locked input 1  PLL lock status.

Function
REQ-013 FSM states: IDLE, RST_PLL, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT; cfg_req is sampled only in IDLE and is ignored in all other states.
REQ-014 In IDLE, on cfg_req with both values legal: latch cfg_mult/cfg_div, go to RST_PLL; cfg_busy=1 from the next cycle.
REQ-015 Illegal value (mult<2, mult>64, div=0, div>64): cfg_err pulses the next cycle, no DRP access, pll_rst unchanged, state stays IDLE.
REQ-016 RST_PLL: pll_rst=1, register index cleared to 0, then go to RD; pll_rst stays 1 until LOCK_WAIT is entered.
REQ-017 Register sequence by index 0..3: daddr 0x08 (CLKOUT0 reg1), 0x09 (CLKOUT0 reg2), 0x14 (CLKFBOUT reg1), 0x15 (CLKFBOUT reg2).
REQ-018 RD: den=1, dwe=0 for exactly one cycle, then RD_WAIT; on drdy, capture drp_do and go to WR.
REQ-019 WR: den=1, dwe=1, di=(captured & keep_mask) | new_bits for exactly one cycle, then WR_WAIT.
REQ-020 WR_WAIT on drdy: if index=3 go to LOCK_WAIT, else increment index and go to RD.
REQ-021 den is never high in two consecutive cycles.
REQ-022 Divider encoding for D (div for 0x08/0x09, mult for 0x14/0x15): high=D>>1, low=D-high, edge=D[0], no_count=(D==1); for D=1, high=low=1.
REQ-023 reg1: keep_mask 0xF000, new_bits = high[5:0] at bits 11:6, low[5:0] at bits 5:0.
REQ-024 reg2: keep_mask 0xFF3F, new_bits = edge at bit 7, no_count at bit 6.
REQ-025 LOCK_WAIT: pll_rst=0; from the next cycle, on pll_locked=1: cfg_done pulses, cfg_busy=0 in that same cycle, and the FSM returns to IDLE.
REQ-026 If drdy and cfg_req occur together, drdy is processed and cfg_req is ignored.
REQ-027 daddr and di hold their last values when den=0.

Reset
REQ-028 On rst, the FSM returns to IDLE, the index is cleared, and all outputs go to 0: cfg_busy, cfg_done, cfg_err, den, dwe, daddr, di, pll_rst.
REQ-029 rst mid-sequence abandons the transaction: pll_rst=0 the next cycle and no further DRP access is made.
REQ-030 A drdy arriving after reset is ignored.

Configuration
REQ-031 Macro PLL_DRP_TIMEOUT_EN defined: a counter starts on entry to RD_WAIT, WR_WAIT or LOCK_WAIT.
REQ-032 When that counter reaches TIMEOUT_CYCLES without drdy (or pll_locked): pll_rst=0, cfg_err pulses, cfg_busy=0, and the FSM returns to IDLE.
REQ-033 Macro undefined: no counter, the FSM waits indefinitely, cfg_err arises only from REQ-015, and TIMEOUT_CYCLES is unused.

Verification
REQ-034 cfg_req with mult=39, div=20, DRP model with drdy 3 cycles after den, all readbacks 0xFFFF -> four read/write pairs to 0x08,0x09,0x14,0x15; writes 0xF28A, 0xFF3F, 0xF4D4, 0xFFBF; then a single cfg_done.
REQ-035 cfg_req with div=1, readbacks 0x0000 -> 0x08 write 0x0041, 0x09 write 0x0040.
REQ-036 cfg_req with mult=1, then with div=65 -> cfg_err pulses each time, den never asserted, cfg_busy stays 0.
REQ-037 Second cfg_req during a transaction -> ignored; exactly one cfg_done; one sequence of 8 den pulses.
REQ-038 rst asserted while in WR_WAIT of index 2 -> next cycle: all outputs 0 and state IDLE; a following legal cfg_req completes normally.
REQ-039 With PLL_DRP_TIMEOUT_EN and TIMEOUT_CYCLES=16, drdy withheld -> cfg_err pulse 16 cycles after entering RD_WAIT, pll_rst=0, cfg_busy=0.
